// File: rtl/ifetch_unit_if.sv
// Instruction-fetch bus: memory-controller request/response plus the decoder hand-off.
// master = fetch unit, slave = controller/decoder side.
interface ifetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  if2ctrl_en;
  logic [ADDR_WIDTH-1:0] next_PC;
  logic                  inst_rdy;
  logic [INST_WIDTH-1:0] inst_out;

  logic                  if2dec_en;
  logic [INST_WIDTH-1:0] if2dec_inst;
  logic [ADDR_WIDTH-1:0] if2dec_PC;
  logic                  if2dec_is_c;
  logic                  if2dec_pred_taken;
  logic [ADDR_WIDTH-1:0] if2dec_pred_PC;

  modport master (
    output if2ctrl_en, next_PC,
    input  inst_rdy, inst_out,
    output if2dec_en, if2dec_inst, if2dec_PC, if2dec_is_c,
           if2dec_pred_taken, if2dec_pred_PC
  );

  modport slave (
    input  if2ctrl_en, next_PC,
    output inst_rdy, inst_out,
    input  if2dec_en, if2dec_inst, if2dec_PC, if2dec_is_c,
           if2dec_pred_taken, if2dec_pred_PC
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: one outstanding request, RVC-aware PC stepping, flush redirect.
// Define IF_PREDICT_EN for static prediction (JAL/C.J taken, backward branches taken).
module ifetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_PC,
  input  logic                  iq_full,
  ifetch_unit_if.master         bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic                  vld;
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  is_c;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] pred_pc;
  } dec_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  req;
  dec_t                  dec;

  logic [INST_WIDTH-1:0] rsp;
  logic                  rsp_is_c;
  logic [ADDR_WIDTH-1:0] seq_pc;
  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] pred_pc;

  assign rsp      = bus.inst_out;
  assign rsp_is_c = (rsp[1:0] != 2'b11);
  assign seq_pc   = pc + (rsp_is_c ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));

`ifdef IF_PREDICT_EN
  logic [31:0] j_imm, b_imm, cj_imm, cb_imm;

  assign j_imm  = {{12{rsp[31]}}, rsp[19:12], rsp[20], rsp[30:21], 1'b0};
  assign b_imm  = {{20{rsp[31]}}, rsp[7], rsp[30:25], rsp[11:8], 1'b0};
  assign cj_imm = {{21{rsp[12]}}, rsp[8], rsp[10:9], rsp[6], rsp[7], rsp[2],
                   rsp[11], rsp[5:3], 1'b0};
  assign cb_imm = {{24{rsp[12]}}, rsp[6:5], rsp[2], rsp[11:10], rsp[4:3], 1'b0};

  // Only direct-target control flow is predicted; register-indirect jumps fall through.
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = seq_pc;
    if (!rsp_is_c) begin
      case (rsp[6:0])
        7'b1101111: begin
          pred_taken = 1'b1;
          pred_pc    = pc + ADDR_WIDTH'(j_imm);
        end
        7'b1100011: if (b_imm[31]) begin
          pred_taken = 1'b1;
          pred_pc    = pc + ADDR_WIDTH'(b_imm);
        end
        default: ;
      endcase
    end else if (rsp[1:0] == 2'b01) begin
      case (rsp[15:13])
        3'b001, 3'b101: begin
          pred_taken = 1'b1;
          pred_pc    = pc + ADDR_WIDTH'(cj_imm);
        end
        3'b110, 3'b111: if (cb_imm[31]) begin
          pred_taken = 1'b1;
          pred_pc    = pc + ADDR_WIDTH'(cb_imm);
        end
        default: ;
      endcase
    end
  end
`else
  assign pred_taken = 1'b0;
  assign pred_pc    = seq_pc;
`endif

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= IDLE;
      pc    <= RESET_PC;
      req   <= 1'b0;
      dec   <= '0;
    end else if (rdy_in) begin
      dec.vld <= 1'b0;
      if (flush) begin
        // Redirect wins over a same-cycle response, which is dropped.
        pc    <= flush_PC;
        state <= IDLE;
        req   <= 1'b0;
      end else begin
        case (state)
          IDLE: if (!iq_full) begin
            state <= WAIT;
            req   <= 1'b1;
          end
          WAIT: if (bus.inst_rdy) begin
            dec.vld     <= 1'b1;
            dec.inst    <= rsp_is_c ? {{(INST_WIDTH-16){1'b0}}, rsp[15:0]} : rsp;
            dec.pc      <= pc;
            dec.is_c    <= rsp_is_c;
            dec.taken   <= pred_taken;
            dec.pred_pc <= pred_pc;
            pc          <= pred_pc;
            state       <= IDLE;
            req         <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.if2ctrl_en        = req;
  assign bus.next_PC           = pc;
  assign bus.if2dec_en         = dec.vld;
  assign bus.if2dec_inst       = dec.inst;
  assign bus.if2dec_PC         = dec.pc;
  assign bus.if2dec_is_c       = dec.is_c;
  assign bus.if2dec_pred_taken = dec.taken;
  assign bus.if2dec_pred_PC    = dec.pred_pc;

endmodule
